// File: rtl/register_file_pkg.sv
// Shared constants and types for the architectural register file.
// Sized for the 32 x 32-bit integer register set.
package register_file_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;

    typedef logic [ADDR_W-1:0] reg_idx_t;
    typedef logic [DATA_W-1:0] word_t;

    localparam reg_idx_t ZERO_REG = '0;

endpackage

// File: rtl/register_file.sv
// Register file: two combinational read ports, one clocked write port.
// Register 0 reads as zero; outty exposes one register for debug display.
module register_file
    import register_file_pkg::*;
#(
    parameter int OUT_REG = 1
) (
    input  logic     clock,
    input  logic     reset,
    input  reg_idx_t readreg1,
    input  reg_idx_t readreg2,
    input  reg_idx_t writereg,
    input  word_t    writedata,
    input  logic     regwrite,
    output word_t    readdata1,
    output word_t    readdata2,
    output word_t    outty
);

    localparam reg_idx_t OUT_IDX = reg_idx_t'(OUT_REG);

    word_t regs [NUM_REGS];

    always_ff @(posedge clock) begin
        if (reset) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else if (regwrite && writereg != ZERO_REG) begin
            regs[writereg] <= writedata;
        end
    end

    // Index 0 is masked on read so it is zero even before the first reset.
    always_comb begin
        readdata1 = (readreg1 == ZERO_REG) ? '0 : regs[readreg1];
        readdata2 = (readreg2 == ZERO_REG) ? '0 : regs[readreg2];
        outty     = (OUT_IDX == ZERO_REG) ? '0 : regs[OUT_IDX];
    end

endmodule

// File: tb/tb_register_file.sv
// Scoreboard bench for register_file: stimulus queues expectations,
// a negedge monitor pops and compares them against the read ports.
module tb_register_file;
    import register_file_pkg::*;

    logic     clock;
    logic     reset;
    reg_idx_t readreg1;
    reg_idx_t readreg2;
    reg_idx_t writereg;
    word_t    writedata;
    logic     regwrite;
    word_t    readdata1;
    word_t    readdata2;
    word_t    outty;

    register_file #(.OUT_REG(1)) dut (
        .clock     (clock),
        .reset     (reset),
        .readreg1  (readreg1),
        .readreg2  (readreg2),
        .writereg  (writereg),
        .writedata (writedata),
        .regwrite  (regwrite),
        .readdata1 (readdata1),
        .readdata2 (readdata2),
        .outty     (outty)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string name;
        int    sel;
        word_t exp;
    } exp_t;

    exp_t q[$];
    int total = 0;
    int bad   = 0;

    // Monitor: outputs are sampled on the falling edge, away from writes.
    always @(negedge clock) begin
        exp_t e;
        word_t act;
        while (q.size() > 0) begin
            e = q.pop_front();
            case (e.sel)
                0:       act = readdata1;
                1:       act = readdata2;
                default: act = outty;
            endcase
            total++;
            if (act !== e.exp) begin
                bad++;
                $display("FAIL %s: got %08h want %08h", e.name, act, e.exp);
            end
        end
    end

    task automatic expect_val(input string name, input int sel,
                              input word_t exp);
        exp_t e;
        e.name = name;
        e.sel  = sel;
        e.exp  = exp;
        q.push_back(e);
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic chk();
        @(negedge clock);
        #1;
    endtask

    task automatic wr(input reg_idx_t a, input word_t d);
        writereg  = a;
        writedata = d;
        regwrite  = 1'b1;
        tick();
        regwrite  = 1'b0;
    endtask

    task automatic sweep_zero(input string name);
        for (int i = 0; i < NUM_REGS; i++) begin
            readreg1 = reg_idx_t'(i);
            readreg2 = reg_idx_t'(NUM_REGS - 1 - i);
            expect_val({name, "_rd1"}, 0, '0);
            expect_val({name, "_rd2"}, 1, '0);
            expect_val({name, "_outty"}, 2, '0);
            chk();
        end
    endtask

    function automatic word_t pat(input int i);
        word_t w;
        w = 32'h0101_0101 * i[31:0];
        return w ^ 32'h8000_0000;
    endfunction

    initial begin
        reset     = 1'b1;
        readreg1  = '0;
        readreg2  = '0;
        writereg  = '0;
        writedata = '0;
        regwrite  = 1'b0;
        tick();
        reset = 1'b0;
        sweep_zero("reset");

        wr(5'd5, 32'hDEAD_BEEF);
        readreg1 = 5'd5;
        readreg2 = 5'd5;
        expect_val("wr_r5_rd1", 0, 32'hDEAD_BEEF);
        expect_val("wr_r5_rd2", 1, 32'hDEAD_BEEF);
        chk();
        writereg  = 5'd5;
        writedata = 32'h1234_5678;
        regwrite  = 1'b0;
        tick();
        expect_val("nowe_r5_rd1", 0, 32'hDEAD_BEEF);
        expect_val("nowe_r5_rd2", 1, 32'hDEAD_BEEF);
        chk();

        wr(5'd0, 32'hFFFF_FFFF);
        readreg1 = 5'd0;
        expect_val("r0_write", 0, 32'h0);
        chk();

        wr(5'd7, 32'h11);
        writereg  = 5'd7;
        writedata = 32'h22;
        regwrite  = 1'b1;
        readreg1  = 5'd7;
        expect_val("r7_before_edge", 0, 32'h11);
        chk();
        tick();
        regwrite = 1'b0;
        expect_val("r7_after_edge", 0, 32'h22);
        chk();

        wr(5'd1, 32'hCAFE_F00D);
        expect_val("outty_r1", 2, 32'hCAFE_F00D);
        chk();
        wr(5'd2, 32'h5555_AAAA);
        readreg2 = 5'd2;
        expect_val("outty_after_r2", 2, 32'hCAFE_F00D);
        expect_val("r2_rd2", 1, 32'h5555_AAAA);
        chk();

        wr(5'd3, 32'h3333_3333);
        reset     = 1'b1;
        writereg  = 5'd3;
        writedata = 32'hA5A5_A5A5;
        regwrite  = 1'b1;
        tick();
        reset    = 1'b0;
        regwrite = 1'b0;
        readreg1 = 5'd3;
        expect_val("rst_prio_r3", 0, 32'h0);
        chk();

        for (int i = 1; i < NUM_REGS; i++) begin
            wr(reg_idx_t'(i), pat(i));
        end
        for (int i = 1; i < NUM_REGS; i++) begin
            readreg1 = reg_idx_t'(i);
            readreg2 = reg_idx_t'(NUM_REGS - i);
            expect_val("fill_rd1", 0, pat(i));
            expect_val("fill_rd2", 1, pat(NUM_REGS - i));
            expect_val("fill_outty", 2, pat(1));
            chk();
        end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        sweep_zero("reset_all");

        chk();
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain: got %0d pending want 0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
